// File: rtl/lcd_write_sched.sv
// lcd_write_sched: runs the HD44780 init sequence, then schedules byte writes from two requesters onto the shared LCD port.
// Define LCD_FIXED_PRIO_EN to make req 0 always win a contention; the default build uses round-robin.
module lcd_write_sched #(
    parameter int TICK_DIV  = 50000,
    parameter int LONG_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        init_done,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_data
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int LW = (LONG_WAIT > 1) ? $clog2(LONG_WAIT) : 1;

    typedef enum logic [2:0] {INIT_LOAD, SETUP, EN_HI, EN_LO, LONG, IDLE} state_t;

    state_t          r_state, w_next, w_exit;
    logic [CW-1:0]   r_cnt;
    logic [LW-1:0]   r_lw;
    logic [1:0]      r_idx;
    logic            r_done, r_rs, r_en;
    logic [7:0]      r_data, w_init_byte, w_data;
    logic            w_tick, w_sel, w_long, w_leave;

`ifdef LCD_FIXED_PRIO_EN
    assign w_sel = ~req_valid[0];
`else
    logic r_rr;
    assign w_sel = (&req_valid) ? ~r_rr : req_valid[1];
    always_ff @(posedge clk) begin
        if (rst)
            r_rr <= 1'b1;
        else if (|gnt)
            r_rr <= w_sel;
    end
`endif

    assign w_tick      = r_cnt == CW'(TICK_DIV - 1);
    assign w_init_byte = (r_idx == 2'd0) ? 8'h38 : (r_idx == 2'd1) ? 8'h0C : (r_idx == 2'd2) ? 8'h06 : 8'h01;
    assign w_data      = w_sel ? req_data[15:8] : req_data[7:0];
    // clear and home commands need the extra settle time
    assign w_long      = !r_rs && r_data[7:2] == 6'd0 && r_data[1:0] != 2'd0 && LONG_WAIT > 0;
    assign w_exit      = (r_idx == 2'd3) ? IDLE : INIT_LOAD;

    always_comb begin
        w_next  = r_state;
        gnt     = 2'b00;
        w_leave = 1'b0;
        case (r_state)
            INIT_LOAD: w_next = SETUP;
            SETUP:     w_next = w_tick ? EN_HI : SETUP;
            EN_HI:     w_next = w_tick ? EN_LO : EN_HI;
            EN_LO: if (w_tick) begin
                w_next  = w_long ? LONG : w_exit;
                w_leave = !w_long;
            end
            LONG: if (w_tick && r_lw == LW'(LONG_WAIT - 1)) begin
                w_next  = w_exit;
                w_leave = 1'b1;
            end
            IDLE: if (|req_valid) begin
                w_next = SETUP;
                gnt    = w_sel ? 2'b10 : 2'b01;
            end
            default: w_next = INIT_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT_LOAD;
            r_cnt   <= '0;
            r_lw    <= '0;
            r_idx   <= 2'd0;
            r_done  <= 1'b0;
            r_rs    <= 1'b0;
            r_en    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_lw    <= (r_state != LONG) ? '0 : w_tick ? r_lw + 1'b1 : r_lw;
            if (r_state == INIT_LOAD) begin
                r_rs   <= 1'b0;
                r_data <= w_init_byte;
            end
            if (|gnt) begin
                r_rs   <= w_sel ? req_rs[1] : req_rs[0];
                r_data <= w_data;
            end
            if (w_tick && r_state == SETUP)
                r_en <= 1'b1;
            if (w_tick && r_state == EN_HI)
                r_en <= 1'b0;
            if (w_leave && r_idx != 2'd3)
                r_idx <= r_idx + 2'd1;
            if (w_leave && r_idx == 2'd3)
                r_done <= 1'b1;
        end
    end

    assign busy      = r_state != IDLE;
    assign init_done = r_done;
    assign lcd_rs    = r_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = r_en;
    assign lcd_data  = r_data;
endmodule
